// File: rtl/binary_raster_source_pkg.sv
// Shared types and default timing for the binary raster replay source.
// Holds the stage-0 state encoding and the payload handed from stage 0 to the alignment stage.
package binary_raster_source_pkg;

  localparam int unsigned CNT_W        = 16;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_H_BLANK  = 1;
  localparam int unsigned DEF_V_PRE    = 1;
  localparam int unsigned DEF_V_POST   = 1;
  localparam int unsigned DEF_ADDR_W   = 19;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_POST   = 3'd4
  } raster_state_e;

  // One stage-0 beat: sync levels, pixel-valid and counter snapshot.
  // cnt_load marks beats whose h/v should be published; other beats hold the previous counters.
  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             active;
    logic             cnt_load;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
  } raster_beat_t;

endpackage

// File: rtl/binary_raster_source_timing_fsm.sv
// Stage 0 of the raster source: frame/line sequencing, h/v/address counters and RAM read strobe.
// RAM controls and busy are registered from the next state so they line up with state_q.
module binary_raster_source_timing_fsm
  import binary_raster_source_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned V_PRE    = DEF_V_PRE,
  parameter int unsigned V_POST   = DEF_V_POST,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_START,
  input  logic              i_CONTINUOUS,
  output logic              o_RD_EN,
  output logic [ADDR_W-1:0] o_RD_ADDR,
  output logic              o_BUSY,
  output raster_beat_t      beat_c,
  output logic              frame_last_c
);

  raster_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  h_q, h_d;
  logic [CNT_W-1:0]  v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              pre_entry;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    h_d          = h_q;
    v_d          = v_q;
    addr_d       = addr_q;
    frame_last_c = 1'b0;
    pre_entry    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_START) begin
          state_d   = ST_PRE;
          pre_entry = 1'b1;
        end
      end

      ST_PRE: begin
        if (cyc_q == CNT_W'(V_PRE - 1)) begin
          state_d = ST_LINE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end

      // v advances as the line ends so HBLANK can already tell whether lines remain
      ST_LINE: begin
        addr_d = addr_q + ADDR_W'(1);
        if (h_q == CNT_W'(H_ACTIVE - 1)) begin
          h_d     = '0;
          v_d     = v_q + CNT_W'(1);
          cyc_d   = '0;
          state_d = ST_HBLANK;
        end else begin
          h_d = h_q + CNT_W'(1);
        end
      end

      ST_HBLANK: begin
        if (cyc_q == CNT_W'(H_BLANK - 1)) begin
          cyc_d   = '0;
          state_d = (v_q == CNT_W'(V_ACTIVE)) ? ST_POST : ST_LINE;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end

      ST_POST: begin
        if (cyc_q == CNT_W'(V_POST - 1)) begin
          frame_last_c = 1'b1;
          cyc_d        = '0;
          if (i_CONTINUOUS) begin
            state_d   = ST_PRE;
            pre_entry = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Every frame starts from pixel (0,0) at address 0
    if (pre_entry) begin
      cyc_d  = '0;
      h_d    = '0;
      v_d    = '0;
      addr_d = '0;
    end

    rd_en_d = (state_d == ST_LINE);
    busy_d  = (state_d != ST_IDLE);

    beat_c.hs       = (state_q == ST_LINE);
    beat_c.vs       = (state_q == ST_LINE) || (state_q == ST_HBLANK);
    beat_c.active   = (state_q == ST_LINE);
    beat_c.cnt_load = (state_q == ST_LINE) || (state_q == ST_PRE);
    beat_c.h        = h_q;
    beat_c.v        = v_q;
  end

  assign o_RD_EN   = rd_en_q;
  assign o_RD_ADDR = addr_q;
  assign o_BUSY    = busy_q;

endmodule

// File: rtl/binary_raster_source.sv
// Replays a 1-bit frame from a synchronous frame RAM as a VGA-style binary raster.
// Stage 1 delays the stage-0 beat by one cycle to line up with the RAM read data.
module binary_raster_source
  import binary_raster_source_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned V_PRE    = DEF_V_PRE,
  parameter int unsigned V_POST   = DEF_V_POST,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_START,
  input  logic              i_CONTINUOUS,
  output logic              o_RD_EN,
  output logic [ADDR_W-1:0] o_RD_ADDR,
  input  logic              i_RD_DATA,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic [CNT_W-1:0]  H_CNT,
  output logic [CNT_W-1:0]  V_CNT,
  output logic              BINARY_FLAG,
  output logic              o_BUSY,
  output logic              o_FRAME_DONE
);

  raster_beat_t     beat_c;
  logic             frame_last_c;

  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             frame_done_q, frame_done_d;

  binary_raster_source_timing_fsm #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_PRE    (V_PRE),
    .V_POST   (V_POST),
    .ADDR_W   (ADDR_W)
  ) u_timing (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_START      (i_START),
    .i_CONTINUOUS (i_CONTINUOUS),
    .o_RD_EN      (o_RD_EN),
    .o_RD_ADDR    (o_RD_ADDR),
    .o_BUSY       (o_BUSY),
    .beat_c       (beat_c),
    .frame_last_c (frame_last_c)
  );

  // Counters hold through HBLANK/POST/IDLE so consumers see the last pixel position
  always_comb begin
    hs_d         = beat_c.hs;
    vs_d         = beat_c.vs;
    active_d     = beat_c.active;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    frame_done_d = frame_last_c;
    if (beat_c.cnt_load) begin
      h_cnt_d = beat_c.h;
      v_cnt_d = beat_c.v;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      active_q     <= 1'b0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      active_q     <= active_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign H_CNT        = h_cnt_q;
  assign V_CNT        = v_cnt_q;
  assign o_FRAME_DONE = frame_done_q;
  // RAM data arrives unregistered; gating keeps blanking pixels at 0
  assign BINARY_FLAG  = i_RD_DATA & active_q;

endmodule

// File: tb/tb_binary_raster_source.sv
// Directed bench for binary_raster_source on a 4x3 frame with a cycle-by-cycle reference model.
module tb_binary_raster_source;

  localparam int unsigned HA = 4;
  localparam int unsigned VA = 3;
  localparam int unsigned HB = 1;
  localparam int unsigned VPRE = 1;
  localparam int unsigned VPOST = 1;
  localparam int unsigned AW = 4;
  localparam int LINE_LEN = HA + HB;
  localparam int FRAME = VPRE + VA * LINE_LEN + VPOST;
  localparam int K_IDLE = 0, K_PRE = 1, K_LINE = 2, K_HB = 3, K_POST = 4;

  logic          CLK;
  logic          RESET;
  logic          i_START;
  logic          i_CONTINUOUS;
  logic          o_RD_EN;
  logic [AW-1:0] o_RD_ADDR;
  logic          i_RD_DATA;
  logic          VGA_HS;
  logic          VGA_VS;
  logic [15:0]   H_CNT;
  logic [15:0]   V_CNT;
  logic          BINARY_FLAG;
  logic          o_BUSY;
  logic          o_FRAME_DONE;

  logic [15:0] mem;
  int tests = 0;
  int fails = 0;
  int m_h = 0;
  int m_v = 0;

  binary_raster_source #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .V_PRE    (VPRE),
    .V_POST   (VPOST),
    .ADDR_W   (AW)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_START      (i_START),
    .i_CONTINUOUS (i_CONTINUOUS),
    .o_RD_EN      (o_RD_EN),
    .o_RD_ADDR    (o_RD_ADDR),
    .i_RD_DATA    (i_RD_DATA),
    .VGA_HS       (VGA_HS),
    .VGA_VS       (VGA_VS),
    .H_CNT        (H_CNT),
    .V_CNT        (V_CNT),
    .BINARY_FLAG  (BINARY_FLAG),
    .o_BUSY       (o_BUSY),
    .o_FRAME_DONE (o_FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  // Synchronous frame RAM: data valid the cycle after the read strobe
  always @(posedge CLK) if (o_RD_EN) i_RD_DATA <= mem[o_RD_ADDR];

  // Stage-0 position for cycle m after the start edge (m = 1 is the first PRE cycle)
  function automatic void s0_model(input int m, input int nfr, output int kind,
                                   output int line, output int pix, output int last);
    int q;
    kind = K_IDLE; line = 0; pix = 0; last = 0;
    if (m >= 1 && m <= nfr * FRAME) begin
      q = (m - 1) % FRAME;
      last = (q == FRAME - 1) ? 1 : 0;
      if (q < VPRE) kind = K_PRE;
      else if (q < VPRE + VA * LINE_LEN) begin
        line = (q - VPRE) / LINE_LEN;
        pix  = (q - VPRE) % LINE_LEN;
        kind = (pix < HA) ? K_LINE : K_HB;
      end else kind = K_POST;
    end
  endfunction

  task automatic run_frames(input string tag, input int nfr, input int restart_at, input int drop_at);
    int k, l, p, lst, pk, pl, pp, plst;
    logic e_busy, e_rden, e_hs, e_vs, e_flag, e_done, prev_hs, prev_vs;
    logic [AW-1:0] e_addr;
    int hs_rise, hs_high, done_cnt, last_vs;
    hs_rise = 0; hs_high = 0; done_cnt = 0; last_vs = -1;
    prev_hs = VGA_HS; prev_vs = VGA_VS;
    i_CONTINUOUS = (nfr > 1);
    i_START = 1'b1;
    for (int n = 1; n <= nfr * FRAME + 3; n++) begin
      @(negedge CLK);
      i_START = (n == restart_at);
      if (n == drop_at) i_CONTINUOUS = 1'b0;
      s0_model(n, nfr, k, l, p, lst);
      s0_model(n - 1, nfr, pk, pl, pp, plst);
      e_busy = (k != K_IDLE);
      e_rden = (k == K_LINE);
      e_addr = AW'(l * HA + p);
      e_hs   = (pk == K_LINE);
      e_vs   = (pk == K_LINE) || (pk == K_HB);
      e_flag = (pk == K_LINE) ? mem[pl * HA + pp] : 1'b0;
      e_done = (pk == K_POST) && (plst != 0);
      if (pk == K_PRE) begin m_h = 0; m_v = 0; end
      else if (pk == K_LINE) begin m_h = pp; m_v = pl; end

      tests++; if (o_BUSY !== e_busy) begin fails++;
        $display("FAIL %s busy n=%0d got %b exp %b", tag, n, o_BUSY, e_busy); end
      tests++; if (o_RD_EN !== e_rden) begin fails++;
        $display("FAIL %s rd_en n=%0d got %b exp %b", tag, n, o_RD_EN, e_rden); end
      if (e_rden) begin
        tests++; if (o_RD_ADDR !== e_addr) begin fails++;
          $display("FAIL %s rd_addr n=%0d got %0d exp %0d", tag, n, o_RD_ADDR, e_addr); end
      end
      tests++; if (VGA_HS !== e_hs) begin fails++;
        $display("FAIL %s hs n=%0d got %b exp %b", tag, n, VGA_HS, e_hs); end
      tests++; if (VGA_VS !== e_vs) begin fails++;
        $display("FAIL %s vs n=%0d got %b exp %b", tag, n, VGA_VS, e_vs); end
      tests++; if (BINARY_FLAG !== e_flag) begin fails++;
        $display("FAIL %s flag n=%0d got %b exp %b", tag, n, BINARY_FLAG, e_flag); end
      tests++; if (o_FRAME_DONE !== e_done) begin fails++;
        $display("FAIL %s frame_done n=%0d got %b exp %b", tag, n, o_FRAME_DONE, e_done); end
      tests++; if (H_CNT !== 16'(m_h)) begin fails++;
        $display("FAIL %s h_cnt n=%0d got %0d exp %0d", tag, n, H_CNT, m_h); end
      tests++; if (V_CNT !== 16'(m_v)) begin fails++;
        $display("FAIL %s v_cnt n=%0d got %0d exp %0d", tag, n, V_CNT, m_v); end

      if (VGA_HS === 1'b1 && prev_hs !== 1'b1) hs_rise++;
      if (VGA_HS === 1'b1) hs_high++;
      if (o_FRAME_DONE === 1'b1) done_cnt++;
      if (VGA_VS === 1'b1 && prev_vs !== 1'b1) begin
        if (last_vs >= 0) begin
          tests++; if (n - last_vs != FRAME) begin fails++;
            $display("FAIL %s vs_period got %0d exp %0d", tag, n - last_vs, FRAME); end
        end
        last_vs = n;
      end
      prev_hs = VGA_HS;
      prev_vs = VGA_VS;
    end
    i_START = 1'b0;
    i_CONTINUOUS = 1'b0;
    tests++; if (hs_rise != VA * nfr) begin fails++;
      $display("FAIL %s hs_rises got %0d exp %0d", tag, hs_rise, VA * nfr); end
    tests++; if (hs_high != HA * VA * nfr) begin fails++;
      $display("FAIL %s hs_high_cycles got %0d exp %0d", tag, hs_high, HA * VA * nfr); end
    tests++; if (done_cnt != nfr) begin fails++;
      $display("FAIL %s frame_done_count got %0d exp %0d", tag, done_cnt, nfr); end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    tests++; if ({o_BUSY, o_RD_EN, VGA_HS, VGA_VS, BINARY_FLAG, o_FRAME_DONE} !== 6'b0) begin fails++;
      $display("FAIL reset flags got %b exp 000000",
               {o_BUSY, o_RD_EN, VGA_HS, VGA_VS, BINARY_FLAG, o_FRAME_DONE}); end
    tests++; if ({H_CNT, V_CNT} !== 32'd0 || o_RD_ADDR !== 4'd0) begin fails++;
      $display("FAIL reset counters got h=%0d v=%0d addr=%0d exp 0", H_CNT, V_CNT, o_RD_ADDR); end
    RESET = 1'b0;
    m_h = 0; m_v = 0;
    @(negedge CLK);
  endtask

  task automatic test_single_frame();
    mem = 16'h0B63;
    run_frames("single", 1, 0, 0);
  endtask

  task automatic test_start_while_busy();
    mem = 16'h04E5;
    run_frames("restart_ignored", 1, 8, 0);
  endtask

  task automatic test_reset_mid_frame();
    i_START = 1'b1;
    @(negedge CLK);
    i_START = 1'b0;
    repeat (9) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    tests++; if ({o_BUSY, o_RD_EN, VGA_HS, VGA_VS, BINARY_FLAG, o_FRAME_DONE} !== 6'b0) begin fails++;
      $display("FAIL mid_reset flags got %b exp 000000",
               {o_BUSY, o_RD_EN, VGA_HS, VGA_VS, BINARY_FLAG, o_FRAME_DONE}); end
    tests++; if ({H_CNT, V_CNT} !== 32'd0 || o_RD_ADDR !== 4'd0) begin fails++;
      $display("FAIL mid_reset counters got h=%0d v=%0d addr=%0d exp 0", H_CNT, V_CNT, o_RD_ADDR); end
    RESET = 1'b0;
    m_h = 0; m_v = 0;
    run_frames("after_reset", 1, 0, 0);
  endtask

  task automatic test_start_with_reset();
    RESET = 1'b1;
    i_START = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    i_START = 1'b0;
    m_h = 0; m_v = 0;
    tests++; if (H_CNT !== 16'd0 || V_CNT !== 16'd0) begin fails++;
      $display("FAIL start_reset counters got h=%0d v=%0d exp 0", H_CNT, V_CNT); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (o_BUSY !== 1'b0 || VGA_HS !== 1'b0 || o_RD_EN !== 1'b0) begin fails++;
        $display("FAIL start_reset idle i=%0d got busy=%b hs=%b rd_en=%b exp 0", i, o_BUSY, VGA_HS, o_RD_EN); end
      @(negedge CLK);
    end
  endtask

  task automatic test_continuous();
    mem = 16'h0A5C;
    run_frames("continuous", 3, 0, 2 * FRAME + 5);
  endtask

  initial begin
    CLK = 1'b0;
    RESET = 1'b1;
    i_START = 1'b0;
    i_CONTINUOUS = 1'b0;
    i_RD_DATA = 1'b0;
    mem = 16'h0B63;
    test_reset();
    test_single_frame();
    test_start_while_busy();
    test_reset_mid_frame();
    test_start_with_reset();
    test_continuous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
